// File: rtl/serial_flit_tx.sv
// Serial flit transmitter: one holding register feeding a shift register, start bit then LSB-first data.
// Build option SERIAL_TX_PARITY_EN appends an even parity bit after the last data bit.
module serial_flit_tx #(
  parameter int FLIT_SZ = 8,
  parameter int ID = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLIT_SZ-1:0] parallel_in,
  input  logic               valid_in,
  output logic               busy,
  input  logic               channel_busy,
  output logic               tx_data,
  output logic               tx_active,
  output logic [19:0]        flit_counter
);

  localparam int CW = $clog2(FLIT_SZ + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FLIT_SZ);

  if (FLIT_SZ < 2 || ID < 0) begin : g_cfg_check
    $error("serial_flit_tx: FLIT_SZ must be >= 2 and ID non-negative");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
`ifdef SERIAL_TX_PARITY_EN
    , PARITY = 2'd3
`endif
  } state_t;

  function automatic logic even_parity(input logic [FLIT_SZ-1:0] data);
    return ^data;
  endfunction

  state_t               state_q, state_d;
  logic [FLIT_SZ-1:0]   hold_q, hold_d;
  logic                 full_q, full_d;
  logic [FLIT_SZ-1:0]   shift_q, shift_d;
  logic [CW-1:0]        bcnt_q, bcnt_d;
  logic                 tx_q, tx_d;
  logic                 act_q, act_d;
  logic [19:0]          fcnt_q, fcnt_d;
  logic                 end_s;
`ifdef SERIAL_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Next-state logic: accept into the holding register, walk the frame, chain frames without a gap
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    full_d  = full_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;
    tx_d    = 1'b0;
    end_s   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif

    // A flit offered while full is dropped; holding contents stay intact
    if (valid_in && !full_q) begin
      hold_d = parallel_in;
      full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b0;
      end
      START: begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[FLIT_SZ-1:1]};
        bcnt_d  = CW'(1);
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bcnt_q < LAST_BIT) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[FLIT_SZ-1:1]};
          bcnt_d  = bcnt_q + CW'(1);
        end else begin
`ifdef SERIAL_TX_PARITY_EN
          tx_d    = par_q;
          state_d = PARITY;
`else
          end_s   = 1'b1;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        end_s = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
        tx_d    = 1'b0;
      end
    endcase

    if (end_s) begin
      fcnt_d  = fcnt_q + 20'd1;
      bcnt_d  = '0;
      state_d = IDLE;
    end else begin
      fcnt_d  = fcnt_q;
    end

    // channel_busy only gates a frame start, never a frame in flight
    if ((state_q == IDLE || end_s) && full_q && !channel_busy) begin
      shift_d = hold_q;
      full_d  = 1'b0;
      tx_d    = 1'b1;
      state_d = START;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = even_parity(hold_q);
`endif
    end else begin
      shift_d = shift_d;
    end

    act_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      bcnt_q  <= '0;
      tx_q    <= 1'b0;
      act_q   <= 1'b0;
      fcnt_q  <= 20'd0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
      fcnt_q  <= fcnt_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign busy         = full_q;
  assign tx_data      = tx_q;
  assign tx_active    = act_q;
  assign flit_counter = fcnt_q;

endmodule

// File: tb/tb_serial_flit_tx.sv
// Randomized and directed bench for serial_flit_tx with a bit-queue reference model of the line.
module tb_serial_flit_tx;

  localparam int FLIT_SZ = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_LEN = FLIT_SZ + 2;
`else
  localparam int FRAME_LEN = FLIT_SZ + 1;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [FLIT_SZ-1:0] parallel_in = '0;
  logic               valid_in = 1'b0;
  logic               busy;
  logic               channel_busy = 1'b0;
  logic               tx_data;
  logic               tx_active;
  logic [19:0]        flit_counter;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: line bits still to send, holding register, counter
  bit                 q_bits[$];
  logic               m_full = 1'b0;
  logic [FLIT_SZ-1:0] m_hold = '0;
  logic [19:0]        m_cnt = 20'd0;
  logic               m_tx = 1'b0;
  logic               m_act = 1'b0;
  logic               m_done = 1'b0;

  serial_flit_tx #(.FLIT_SZ(FLIT_SZ), .ID(0)) dut (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .valid_in(valid_in),
    .busy(busy), .channel_busy(channel_busy), .tx_data(tx_data),
    .tx_active(tx_active), .flit_counter(flit_counter)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q_bits.delete();
    m_full = 1'b0; m_cnt = 20'd0; m_tx = 1'b0; m_act = 1'b0; m_done = 1'b0;
  endtask

  // Drive inputs, advance one edge, update the model, then settle #1 after the edge
  task automatic tick(input logic v, input logic [FLIT_SZ-1:0] d, input logic cb);
    logic acc;
    valid_in = v; parallel_in = d; channel_busy = cb;
    @(posedge clk);
    acc = v && !m_full;
    if (q_bits.size() > 0) begin
      m_tx = q_bits.pop_front();
      m_act = 1'b1;
      if (q_bits.size() == 0) m_done = 1'b1;
    end else begin
      if (m_done) begin
        m_cnt = m_cnt + 20'd1;
        m_done = 1'b0;
      end
      if (m_full && !cb) begin
        q_bits.push_back(1'b1);
        for (int i = 0; i < FLIT_SZ; i++) q_bits.push_back(m_hold[i]);
`ifdef SERIAL_TX_PARITY_EN
        q_bits.push_back(^m_hold);
`endif
        m_tx = q_bits.pop_front();
        m_act = 1'b1;
        m_full = 1'b0;
      end else begin
        m_tx = 1'b0;
        m_act = 1'b0;
      end
    end
    if (acc) begin
      m_full = 1'b1;
      m_hold = d;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (tx_data !== 1'b0) $display("FAIL reset_tx_data got %b exp 0", tx_data); else n_pass++;
    n_checks++;
    if (tx_active !== 1'b0) $display("FAIL reset_tx_active got %b exp 0", tx_active); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++;
    if (flit_counter !== 20'd0) $display("FAIL reset_counter got %0d exp 0", flit_counter); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset_midframe();
    tick(1'b1, 8'h96, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b0);
    n_checks++;
    if (tx_active !== 1'b1) $display("FAIL midreset_pre_active got %b exp 1", tx_active); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({tx_data, tx_active, busy} !== 3'b000)
      $display("FAIL midreset_outputs got %b exp 000", {tx_data, tx_active, busy});
    else n_pass++;
    n_checks++;
    if (flit_counter !== 20'd0) $display("FAIL midreset_counter got %0d exp 0", flit_counter); else n_pass++;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < FRAME_LEN + 2; i++) begin
      tick(1'b0, '0, 1'b0);
      n_checks++;
      if ({tx_data, tx_active, busy, flit_counter} !== {m_tx, m_act, m_full, m_cnt})
        $display("FAIL midreset_after cyc %0d got %b_%b_%b_%0d exp %b_%b_%b_%0d", i,
                 tx_data, tx_active, busy, flit_counter, m_tx, m_act, m_full, m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (flit_counter !== 20'd1) $display("FAIL midreset_count got %0d exp 1", flit_counter); else n_pass++;
  endtask

  task automatic test_single();
    int exp_line [0:10] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    logic [19:0] base;
    base = m_cnt;
    tick(1'b1, 8'hA5, 1'b0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy_accept got %b exp 1", busy); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, '0, 1'b0);
      n_checks++;
      if (tx_data !== exp_line[i][0] || busy !== 1'b0)
        $display("FAIL single_line E%0d got tx=%b busy=%b exp tx=%0d busy=0", i + 1, tx_data, busy, exp_line[i]);
      else n_pass++;
      n_checks++;
      if ({tx_data, tx_active, busy, flit_counter} !== {m_tx, m_act, m_full, m_cnt})
        $display("FAIL single_model E%0d got %b_%b_%b_%0d exp %b_%b_%b_%0d", i + 1,
                 tx_data, tx_active, busy, flit_counter, m_tx, m_act, m_full, m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (flit_counter !== base + 20'd1) $display("FAIL single_count got %0d exp %0d", flit_counter, base + 20'd1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [FLIT_SZ-1:0] flits [0:1] = '{8'h01, 8'h80};
    int idx = 0;
    int run = 0;
    int max_run = 0;
    logic [19:0] base;
    base = m_cnt;
    for (int i = 0; i < 2 * FRAME_LEN + 6; i++) begin
      if (idx < 2 && !m_full) begin
        tick(1'b1, flits[idx], 1'b0);
        idx++;
      end else begin
        tick(1'b0, '0, 1'b0);
      end
      n_checks++;
      if ({tx_data, tx_active, busy, flit_counter} !== {m_tx, m_act, m_full, m_cnt})
        $display("FAIL b2b_model cyc %0d got %b_%b_%b_%0d exp %b_%b_%b_%0d", i,
                 tx_data, tx_active, busy, flit_counter, m_tx, m_act, m_full, m_cnt);
      else n_pass++;
      if (tx_active) run++;
      else begin
        if (run > max_run) max_run = run;
        run = 0;
      end
    end
    n_checks++;
    if (max_run != 2 * FRAME_LEN) $display("FAIL b2b_run got %0d exp %0d", max_run, 2 * FRAME_LEN); else n_pass++;
    n_checks++;
    if (flit_counter !== base + 20'd2) $display("FAIL b2b_count got %0d exp %0d", flit_counter, base + 20'd2); else n_pass++;
  endtask

  task automatic test_channel_busy();
    tick(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, '0, 1'b1);
      n_checks++;
      if (tx_data !== 1'b0 || busy !== 1'b1 || tx_active !== 1'b0)
        $display("FAIL cbusy_hold cyc %0d got tx=%b busy=%b act=%b exp 0 1 0", i, tx_data, busy, tx_active);
      else n_pass++;
    end
    tick(1'b0, '0, 1'b0);
    n_checks++;
    if (tx_data !== 1'b1 || busy !== 1'b0) $display("FAIL cbusy_start got tx=%b busy=%b exp 1 0", tx_data, busy); else n_pass++;
    for (int i = 0; i < FRAME_LEN + 1; i++) begin
      tick(1'b0, '0, 1'b0);
      n_checks++;
      if ({tx_data, tx_active, busy, flit_counter} !== {m_tx, m_act, m_full, m_cnt})
        $display("FAIL cbusy_drain cyc %0d got %b_%b_%b_%0d exp %b_%b_%b_%0d", i,
                 tx_data, tx_active, busy, flit_counter, m_tx, m_act, m_full, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_midframe_cbusy();
    logic cb;
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b0, '0, 1'b0);
    for (int i = 0; i < FRAME_LEN + 14; i++) begin
      cb = (i >= 3 && i < FRAME_LEN + 6);
      tick(i == 0, 8'hC3, cb);
      n_checks++;
      if ({tx_data, tx_active, busy, flit_counter} !== {m_tx, m_act, m_full, m_cnt})
        $display("FAIL midcb_model cyc %0d got %b_%b_%b_%0d exp %b_%b_%b_%0d", i,
                 tx_data, tx_active, busy, flit_counter, m_tx, m_act, m_full, m_cnt);
      else n_pass++;
      if (i == FRAME_LEN + 4) begin
        n_checks++;
        if (tx_active !== 1'b0 || busy !== 1'b1)
          $display("FAIL midcb_wait got act=%b busy=%b exp 0 1", tx_active, busy);
        else n_pass++;
      end
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    int exp_line [0:10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    int act_cycles = 0;
    tick(1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, '0, 1'b0);
      if (tx_active) act_cycles++;
      n_checks++;
      if (tx_data !== exp_line[i][0])
        $display("FAIL parity_line E%0d got %b exp %0d", i + 1, tx_data, exp_line[i]);
      else n_pass++;
    end
    n_checks++;
    if (act_cycles != 10) $display("FAIL parity_len got %0d exp 10", act_cycles); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic v;
    logic cb;
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      cb = ($urandom_range(0, 5) == 0);
      tick(v, FLIT_SZ'($urandom), cb);
      n_checks++;
      if ({tx_data, tx_active, busy, flit_counter} !== {m_tx, m_act, m_full, m_cnt})
        $display("FAIL random cyc %0d got %b_%b_%b_%0d exp %b_%b_%b_%0d", i,
                 tx_data, tx_active, busy, flit_counter, m_tx, m_act, m_full, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_single();
    test_back_to_back();
    test_channel_busy();
    test_midframe_cbusy();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
